// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with flush > hold > stall > load priority and a VALID/BUBBLE tag.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_pipe_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        hold,
    input  logic        reg_dst_id,
    input  logic        alu_src_id,
    input  logic [2:0]  alu_op_id,
    input  logic        mem_read_id,
    input  logic        mem_write_id,
    input  logic        reg_write_id,
    input  logic        mem_to_reg_id,
    input  logic [31:0] pc_plus4_id,
    input  logic [31:0] rd1_id,
    input  logic [31:0] rd2_id,
    input  logic [31:0] imm_id,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic [4:0]  rd_id,
    output logic        reg_dst_ex,
    output logic        alu_src_ex,
    output logic [2:0]  alu_op_ex,
    output logic        mem_read_ex,
    output logic        mem_write_ex,
    output logic        reg_write_ex,
    output logic        mem_to_reg_ex,
    output logic [31:0] pc_plus4_ex,
    output logic [31:0] rd1_ex,
    output logic [31:0] rd2_ex,
    output logic [31:0] imm_ex,
    output logic [4:0]  rs_ex,
    output logic [4:0]  rt_ex,
    output logic [4:0]  rd_ex,
    output logic        valid_ex
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [15:0] bubble_cnt
`endif
);

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } data_t;

    typedef enum logic {BUBBLE = 1'b0, VALID = 1'b1} state_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d, ctrl_in;
    data_t  data_q, data_d, data_in;

    assign ctrl_in = '{reg_dst_id, alu_src_id, alu_op_id, mem_read_id,
                       mem_write_id, reg_write_id, mem_to_reg_id};
    assign data_in = '{pc_plus4_id, rd1_id, rd2_id, imm_id, rs_id, rt_id, rd_id};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BUBBLE;
        else        state_q <= state_d;
    end

    // Bubbles always carry a zero control word, so they can never write memory or registers.
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (flush) begin
            state_d = BUBBLE;
            ctrl_d  = '0;
            data_d  = '0;
        end else if (!hold) begin
            data_d = data_in;
            if (stall) begin
                state_d = BUBBLE;
                ctrl_d  = '0;
            end else begin
                state_d = VALID;
                ctrl_d  = ctrl_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    assign reg_dst_ex    = ctrl_q.reg_dst;
    assign alu_src_ex    = ctrl_q.alu_src;
    assign alu_op_ex     = ctrl_q.alu_op;
    assign mem_read_ex   = ctrl_q.mem_read;
    assign mem_write_ex  = ctrl_q.mem_write;
    assign reg_write_ex  = ctrl_q.reg_write;
    assign mem_to_reg_ex = ctrl_q.mem_to_reg;
    assign pc_plus4_ex   = data_q.pc_plus4;
    assign rd1_ex        = data_q.rd1;
    assign rd2_ex        = data_q.rd2;
    assign imm_ex        = data_q.imm;
    assign rs_ex         = data_q.rs;
    assign rt_ex         = data_q.rt;
    assign rd_ex         = data_q.rd;
    assign valid_ex      = (state_q == VALID);

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] bubble_q;

    // A flush under hold does not count; the counter saturates rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bubble_q <= '0;
        else if (!hold && (flush || stall) && bubble_q != 16'hFFFF)
            bubble_q <= bubble_q + 16'd1;
    end

    assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed steps plus randomized traffic
// against a priority-rule reference model.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, hold;
    logic        reg_dst_id, alu_src_id, mem_read_id, mem_write_id, reg_write_id, mem_to_reg_id;
    logic [2:0]  alu_op_id;
    logic [31:0] pc_plus4_id, rd1_id, rd2_id, imm_id;
    logic [4:0]  rs_id, rt_id, rd_id;
    logic        reg_dst_ex, alu_src_ex, mem_read_ex, mem_write_ex, reg_write_ex, mem_to_reg_ex;
    logic [2:0]  alu_op_ex;
    logic [31:0] pc_plus4_ex, rd1_ex, rd2_ex, imm_ex;
    logic [4:0]  rs_ex, rt_ex, rd_ex;
    logic        valid_ex;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [8:0]   e_ctrl;
    logic [127:0] e_data;
    logic [14:0]  e_idx;
    logic         e_valid;
    int           e_cnt;

    id_ex_pipe_reg dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .hold(hold),
        .reg_dst_id(reg_dst_id), .alu_src_id(alu_src_id), .alu_op_id(alu_op_id),
        .mem_read_id(mem_read_id), .mem_write_id(mem_write_id), .reg_write_id(reg_write_id),
        .mem_to_reg_id(mem_to_reg_id), .pc_plus4_id(pc_plus4_id), .rd1_id(rd1_id),
        .rd2_id(rd2_id), .imm_id(imm_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
        .reg_dst_ex(reg_dst_ex), .alu_src_ex(alu_src_ex), .alu_op_ex(alu_op_ex),
        .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex), .reg_write_ex(reg_write_ex),
        .mem_to_reg_ex(mem_to_reg_ex), .pc_plus4_ex(pc_plus4_ex), .rd1_ex(rd1_ex),
        .rd2_ex(rd2_ex), .imm_ex(imm_ex), .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex),
        .valid_ex(valid_ex)
`ifdef ID_EX_BUBBLE_CNT_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_ctrl = '0; e_data = '0; e_idx = '0; e_valid = 1'b0; e_cnt = 0;
    endtask

    // Priority rules: flush > hold > stall > load; counter steps on unheld stall/flush.
    task automatic model_step();
        logic [8:0]   c_in;
        logic [127:0] d_in;
        logic [14:0]  i_in;
        c_in = {reg_dst_id, alu_src_id, alu_op_id, mem_read_id, mem_write_id,
                reg_write_id, mem_to_reg_id};
        d_in = {pc_plus4_id, rd1_id, rd2_id, imm_id};
        i_in = {rs_id, rt_id, rd_id};
        if (!hold && (flush || stall) && e_cnt < 65535) e_cnt++;
        if (flush) begin
            e_ctrl = '0; e_data = '0; e_idx = '0; e_valid = 1'b0;
        end else if (hold) begin
            e_valid = e_valid;
        end else if (stall) begin
            e_ctrl = '0; e_data = d_in; e_idx = i_in; e_valid = 1'b0;
        end else begin
            e_ctrl = c_in; e_data = d_in; e_idx = i_in; e_valid = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ctrl"}, 160'({reg_dst_ex, alu_src_ex, alu_op_ex, mem_read_ex, mem_write_ex,
                                  reg_write_ex, mem_to_reg_ex}), 160'(e_ctrl));
        chk({tag, ".data"}, 160'({pc_plus4_ex, rd1_ex, rd2_ex, imm_ex}), 160'(e_data));
        chk({tag, ".idx"}, 160'({rs_ex, rt_ex, rd_ex}), 160'(e_idx));
        chk({tag, ".valid"}, 160'(valid_ex), 160'(e_valid));
        chk({tag, ".nosidefx"}, 160'({mem_write_ex, reg_write_ex} & {2{~valid_ex}}), 160'(0));
`ifdef ID_EX_BUBBLE_CNT_EN
        chk({tag, ".cnt"}, 160'(bubble_cnt), 160'(e_cnt));
`endif
    endtask

    task automatic rand_inputs();
        reg_dst_id = 1'($urandom); alu_src_id = 1'($urandom); alu_op_id = 3'($urandom);
        mem_read_id = 1'($urandom); mem_write_id = 1'($urandom);
        reg_write_id = 1'($urandom); mem_to_reg_id = 1'($urandom);
        pc_plus4_id = $urandom; rd1_id = $urandom; rd2_id = $urandom; imm_id = $urandom;
        rs_id = 5'($urandom); rt_id = 5'($urandom); rd_id = 5'($urandom);
    endtask

    task automatic set_ctl(input logic f, input logic h, input logic s);
        flush = f; hold = h; stall = s;
    endtask

    // Inputs are applied at the falling edge; outputs are checked at the next falling edge.
    task automatic cycle(input string tag);
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        set_ctl(1'b0, 1'b0, 1'b0);
        rand_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // Normal load
        rand_inputs();
        rd1_id = 32'hDEADBEEF; reg_write_id = 1'b1; alu_op_id = 3'b010;
        cycle("normal");
        chk("normal.rd1", 160'(rd1_ex), 160'(32'hDEADBEEF));
        chk("normal.regw", 160'(reg_write_ex), 160'(1));
        chk("normal.aluop", 160'(alu_op_ex), 160'(3'b010));
        chk("normal.valid", 160'(valid_ex), 160'(1));

        // Stall inserts a bubble but passes indices through
        rand_inputs();
        set_ctl(1'b0, 1'b0, 1'b1);
        mem_read_id = 1'b1; rt_id = 5'd7;
        cycle("stall");
        chk("stall.memrd", 160'(mem_read_ex), 160'(0));
        chk("stall.rt", 160'(rt_ex), 160'(7));
        chk("stall.valid", 160'(valid_ex), 160'(0));

        // Load a real instruction, hold it for 3 cycles, then flush under hold
        rand_inputs();
        set_ctl(1'b0, 1'b0, 1'b0);
        cycle("preload");
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            set_ctl(1'b0, 1'b1, 1'(i == 1));
            cycle("hold");
        end
        chk("hold.valid", 160'(valid_ex), 160'(1));
        rand_inputs();
        set_ctl(1'b1, 1'b1, 1'b0);
        cycle("flush_hold");
        chk("flush_hold.data", 160'({pc_plus4_ex, rd1_ex, rd2_ex, imm_ex, rs_ex, rt_ex, rd_ex}), 160'(0));
        chk("flush_hold.valid", 160'(valid_ex), 160'(0));

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            set_ctl(1'($urandom_range(7, 0) == 0), 1'($urandom_range(4, 0) == 0),
                    1'($urandom_range(3, 0) == 0));
            cycle("rand");
        end

        // Asynchronous reset in the middle of a hold
        rand_inputs();
        set_ctl(1'b0, 1'b0, 1'b0);
        cycle("pre_reset");
        rand_inputs();
        set_ctl(1'b0, 1'b1, 1'b0);
        cycle("hold_pre_reset");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(negedge clk);
        check_all("in_reset");
        rst_n = 1'b1;
        rand_inputs();
        set_ctl(1'b0, 1'b0, 1'b0);
        cycle("after_reset");

`ifdef ID_EX_BUBBLE_CNT_EN
        set_ctl(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
            model_step();
        end
        @(negedge clk);
        check_all("saturate");
        chk("saturate.cnt_max", 160'(bubble_cnt), 160'(16'hFFFF));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
